// File: rtl/hog_stream_pkg.sv
// Shared stream framing definitions for the window serializer/deserializer pair:
// header layout, sync marker, FSM state type and the beat-count helper.
package hog_stream_pkg;

  localparam logic [7:0] SYNC_MARKER = 8'hA5;
  localparam int         MARKER_W    = 8;
  // Metadata sits at the bottom of the header; the marker sits at the top.
  localparam int         META_LSB    = 0;

  typedef enum logic [1:0] {
    HEADER = 2'd0,
    DATA   = 2'd1,
    OUT    = 2'd2
  } deser_state_e;

  function automatic int num_beats(input int win_w, input int bus_w);
    return (win_w + bus_w - 1) / bus_w;
  endfunction

endpackage

// File: rtl/window_deserializer.sv
// Reassembles a header + NUM_BEATS data-beat stream frame into one wide window.
// Optional macro WINDOW_DESER_SYNC_CHECK_EN drops headers with a bad sync marker.
module window_deserializer
  import hog_stream_pkg::*;
#(
  parameter int WINDOW_WIDTH = 1152,
  parameter int BUS_WIDTH    = 128,
  parameter int META_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BUS_WIDTH-1:0]    stream,
  input  logic                    stream_valid,
  output logic                    stream_ready,
  output logic [WINDOW_WIDTH-1:0] window,
  output logic [META_WIDTH-1:0]   metadata,
  output logic                    window_valid,
  input  logic                    window_ready,
  output logic                    sync_error
);

  localparam int NB     = num_beats(WINDOW_WIDTH, BUS_WIDTH);
  localparam int CW     = $clog2(NB + 1);
  localparam int LAST_W = WINDOW_WIDTH - (NB - 1) * BUS_WIDTH;
  localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);

  deser_state_e            state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    ready_q;
  logic [WINDOW_WIDTH-1:0] win_q;
  logic [META_WIDTH-1:0]   meta_q;
  logic                    hs, hdr_ok, hdr_take, beat_we;

  assign hs = stream_valid & ready_q;

`ifdef WINDOW_DESER_SYNC_CHECK_EN
  assign hdr_ok = (stream[BUS_WIDTH-1 -: MARKER_W] == SYNC_MARKER);
`else
  assign hdr_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hdr_take = 1'b0;
    beat_we  = 1'b0;
    case (state_q)
      HEADER: if (hs) begin
        cnt_d = '0;
        if (hdr_ok) begin
          hdr_take = 1'b1;
          state_d  = DATA;
        end
      end
      DATA: if (hs) begin
        beat_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = OUT;
      end
      OUT: if (window_ready) state_d = HEADER;
      default: state_d = HEADER;
    endcase
  end

  // ready is a pure function of the next state, so window_ready never reaches
  // stream_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HEADER;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d != OUT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) meta_q <= '0;
    else if (hdr_take) meta_q <= stream[META_LSB +: META_WIDTH];
  end

  // The final beat only contributes the bits that still fit inside the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
    end else if (beat_we) begin
      for (int k = 0; k < NB - 1; k++)
        if (cnt_q == CW'(k)) win_q[k*BUS_WIDTH +: BUS_WIDTH] <= stream;
      if (cnt_q == LAST_CNT)
        win_q[(NB-1)*BUS_WIDTH +: LAST_W] <= stream[LAST_W-1:0];
    end
  end

`ifdef WINDOW_DESER_SYNC_CHECK_EN
  logic sync_err_q;
  always_ff @(posedge clk) begin
    if (rst) sync_err_q <= 1'b0;
    else     sync_err_q <= (state_q == HEADER) & hs & ~hdr_ok;
  end
  assign sync_error = sync_err_q;
`else
  assign sync_error = 1'b0;
`endif

  assign stream_ready = ready_q;
  assign window_valid = (state_q == OUT);
  assign window       = win_q;
  assign metadata     = meta_q;

endmodule

// File: tb/tb_window_deserializer.sv
// Scoreboard bench for window_deserializer: frames are modelled as plain beat
// arrays; a negedge monitor compares every presented window against the queue.
module tb_window_deserializer;
  import hog_stream_pkg::*;

  localparam int WW = 1152;
  localparam int BW = 128;
  localparam int MW = 4;
  localparam int NB = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BW-1:0] stream = '0;
  logic          stream_valid = 1'b0;
  logic          stream_ready;
  logic [WW-1:0] window;
  logic [MW-1:0] metadata;
  logic          window_valid;
  logic          window_ready = 1'b1;
  logic          sync_error;

  always #5 clk = ~clk;

  window_deserializer #(.WINDOW_WIDTH(WW), .BUS_WIDTH(BW), .META_WIDTH(MW)) dut (
    .clk(clk), .rst(rst), .stream(stream), .stream_valid(stream_valid),
    .stream_ready(stream_ready), .window(window), .metadata(metadata),
    .window_valid(window_valid), .window_ready(window_ready), .sync_error(sync_error)
  );

  typedef struct {
    logic [WW-1:0] win;
    logic [MW-1:0] meta;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  int   total = 0, bad = 0, cyc = 0, n_win = 0;
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk) if (rand_rdy) begin
    #1 window_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  // Monitor: every cycle a window is presented it must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    int   badk;
    if (!rst && window_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_window meta=%0h", metadata);
      end else begin
        e    = sb[0];
        badk = -1;
        for (int k = 0; k < NB; k++)
          if (window[k*BW +: BW] !== e.win[k*BW +: BW]) badk = k;
        if (badk >= 0 || metadata !== e.meta) begin
          bad++;
          if (badk < 0) badk = 0;
          $display("FAIL window beat=%0d got=%h want=%h meta got=%0h want=%0h",
                   badk, window[badk*BW +: BW], e.win[badk*BW +: BW], metadata, e.meta);
        end
        if (window_ready) begin
          void'(sb.pop_front());
          n_win++;
          hs_cyc.push_back(cyc);
        end
      end
    end
  end

  function automatic logic [BW-1:0] mk_hdr(input logic [7:0] mark, input logic [MW-1:0] meta);
    logic [BW-1:0] h;
    h = '0;
    h[BW-1 -: 8] = mark;
    h[MW-1:0]    = meta;
    return h;
  endfunction

  function automatic int gap_of(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
    return 0;
  endfunction

  task automatic send_beat(input logic [BW-1:0] d, input int gap);
    int g;
    repeat (gap) begin
      @(negedge clk);
      stream_valid = 1'b0;
    end
    @(negedge clk);
    stream       = d;
    stream_valid = 1'b1;
    g = 0;
    while (!stream_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!stream_ready) begin
      total++;
      bad++;
      $display("FAIL beat_timeout got=ready0 want=ready1");
    end
    @(posedge clk);
  endtask

  // mode: 0 back-to-back, 1 valid toggling, 2 random bubbles; pat: beat k = k+1
  task automatic send_frame(input logic [MW-1:0] meta, input int mode, input bit pat,
                            input logic [7:0] mark = SYNC_MARKER);
    logic [BW-1:0] h, b;
    exp_t e;
    h = mk_hdr(mark, meta);
    if (mode == 2) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      h[BW-9:MW] = b[BW-9:MW];
    end
    send_beat(h, gap_of(mode));
    e.win  = '0;
    e.meta = meta;
    for (int k = 0; k < NB; k++) begin
      b = pat ? BW'(k + 1) : {$urandom, $urandom, $urandom, $urandom};
      send_beat(b, gap_of(mode));
      e.win[k*BW +: BW] = b;
    end
    sb.push_back(e);
    @(negedge clk);
    stream_valid = 1'b0;
    chk("valid_after_last_beat", window_valid, 1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got=%0d want=0", sb.size());
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    stream_valid = 1'b0;
    repeat (n) @(negedge clk);
    chk("rst_stream_ready", stream_ready, 0);
    chk("rst_window_valid", window_valid, 0);
    chk("rst_sync_error", sync_error, 0);
    chk("rst_metadata", metadata, 0);
    chk("rst_window_zero", (window == '0), 1);
    sb.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", stream_ready, 1);
  endtask

  initial begin
    int n0;
    do_reset(3);

    // single frame, ready held high: valid for exactly one cycle
    send_frame(4'd7, 0, 1'b1);
    drain();
    chk("valid_one_cycle", window_valid, 0);

    // downstream stall for 5 cycles
    window_ready = 1'b0;
    send_frame(4'd7, 0, 1'b1);
    chk("stall_ready_low", stream_ready, 0);
    repeat (4) begin
      @(negedge clk);
      chk("stall_valid_held", window_valid, 1);
      chk("stall_ready_low", stream_ready, 0);
    end
    @(posedge clk);
    #1 window_ready = 1'b1;
    @(negedge clk);
    chk("stall_valid_6th", window_valid, 1);
    @(negedge clk);
    chk("stall_released", window_valid, 0);
    chk("stall_ready_back", stream_ready, 1);

    // valid toggling every cycle
    send_frame(4'd7, 1, 1'b1);
    drain();

    // reset mid-frame, then a clean frame
    n0 = n_win;
    send_beat(mk_hdr(SYNC_MARKER, 4'd5), 0);
    for (int k = 0; k < 4; k++) send_beat(BW'(16'hdead + k), 0);
    do_reset(2);
    send_frame(4'd3, 0, 1'b1);
    drain();
    chk("one_window_after_rst", n_win - n0, 1);

    // reset while a window is pending
    window_ready = 1'b0;
    send_frame(4'd9, 0, 1'b0);
    do_reset(2);
    window_ready = 1'b1;
    chk("pending_discarded", window_valid, 0);
    send_frame(4'd10, 0, 1'b0);
    drain();

`ifdef WINDOW_DESER_SYNC_CHECK_EN
    send_beat(mk_hdr(8'h00, 4'd6), 0);
    @(negedge clk);
    stream_valid = 1'b0;
    chk("sync_error_pulse", sync_error, 1);
    @(negedge clk);
    chk("sync_error_one_cycle", sync_error, 0);
    chk("bad_hdr_stays_header", stream_ready, 1);
    send_frame(4'd4, 0, 1'b1);
    drain();
`else
    // without marker checking any beat in HEADER is a header
    send_frame(4'd6, 0, 1'b1, 8'h00);
    chk("no_sync_error", sync_error, 0);
    drain();
`endif

    // back-to-back frames: one window every NB+2 cycles
    n0 = hs_cyc.size();
    send_frame(4'd1, 0, 1'b1);
    send_frame(4'd2, 0, 1'b1);
    drain();
    if (hs_cyc.size() >= n0 + 2)
      chk("throughput_spacing", hs_cyc[n0+1] - hs_cyc[n0], NB + 2);
    else
      chk("throughput_windows", hs_cyc.size() - n0, 2);

    // randomized frames, bubbles and downstream back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) send_frame(MW'($urandom), 2, 1'b0);
    @(negedge clk);
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 window_ready = 1'b1;
    drain();
    chk("scoreboard_empty", sb.size(), 0);
    chk("sync_error_idle", sync_error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
